ram_access_arbiter: RTL and testbench

Sequencer and arbiter for the single-port RAM in the SPARC datapath. Shares the RAM between the instruction-fetch requester and the load/store requester. For each granted access it loads MAR, drives RAM_enable/RAM_OpCode and waits on the MFC handshake. An optional watchdog converts a missing MFC into a bus error. It sits between the control unit's fetch/memory states and the datapath's MAR/RAM control inputs.

---
 rtl/sparc_mem_pkg.sv | 21 ++
 rtl/ram_access_arbiter_if.sv | 30 +++
 rtl/ram_watchdog.sv | 31 +++
 rtl/ram_access_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared types and constants for the SPARC datapath RAM access path.
package sparc_mem_pkg;

   localparam int unsigned RAM_OP_W = 6;

   // Instruction fetch is always a word load.
   localparam logic [RAM_OP_W-1:0] FETCH_OPCODE = 6'b000000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD_MAR = 2'd1,
      ST_ACCESS   = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Request/handshake bundle between the control unit, the RAM arbiter and the MAR/RAM controls.
interface ram_access_arbiter_if;
   import sparc_mem_pkg::*;

   logic                if_req;
   logic [31:0]         if_addr;
   logic                if_done;
   logic                ls_req;
   logic [31:0]         ls_addr;
   logic [RAM_OP_W-1:0] ls_opcode;
   logic                ls_done;
   logic                MAR_Enable;
   logic [31:0]         mar_addr;
   logic                RAM_enable;
   logic [RAM_OP_W-1:0] RAM_OpCode;
   logic                MFC;
   logic                bus_error;
   logic                busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_addr, ls_opcode, MFC,
      output if_done, ls_done, MAR_Enable, mar_addr, RAM_enable, RAM_OpCode, bus_error, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_addr, ls_opcode, MFC,
      input  if_done, ls_done, MAR_Enable, mar_addr, RAM_enable, RAM_OpCode, bus_error, busy
   );

endinterface

// File: rtl/ram_watchdog.sv
// MFC watchdog: counts ACCESS cycles without MFC and flags expiry on the last allowed one.
// Used by ram_access_arbiter only when RAM_TIMEOUT_EN is defined.
module ram_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_active,
   input  logic i_mfc,
   output logic o_expired
);

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 32'd1);

   logic [7:0] r_count;

   // Cycle counter, held at zero whenever the arbiter is outside ACCESS.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= 8'd0;
      end else if (!i_active) begin
         r_count <= 8'd0;
      end else if (!i_mfc) begin
         r_count <= r_count + 8'd1;
      end
   end

   // MFC in the expiry cycle takes precedence over the error.
   assign o_expired = i_active && !i_mfc && (r_count == LAST_COUNT);

endmodule

// File: rtl/ram_access_arbiter.sv
// Single-port RAM sequencer: arbitrates fetch vs load/store, drives MAR and RAM strobes, waits on MFC.
// Defining RAM_TIMEOUT_EN adds an MFC watchdog that ends a stuck access with bus_error.
module ram_access_arbiter
   import sparc_mem_pkg::*;
`ifdef RAM_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
)
`endif
(
   input  logic                i_clk,
   input  logic                i_rst,
   ram_access_arbiter_if.slave io_bus
);

   state_t              r_state;
   state_t              w_next_state;
   owner_t              r_owner;
   owner_t              r_last_owner;
   logic [31:0]         r_addr;
   logic [RAM_OP_W-1:0] r_opcode;

   logic                w_grant;
   owner_t              w_grant_owner;
   logic                w_in_access;
   logic                w_expired;

   logic                w_mar_enable;
   logic                w_ram_enable;
   logic [RAM_OP_W-1:0] w_ram_opcode;
   logic                w_if_done;
   logic                w_ls_done;
   logic                w_bus_error;
   logic                w_busy;

   logic                r_mar_enable;
   logic                r_ram_enable;
   logic [RAM_OP_W-1:0] r_ram_opcode;
   logic                r_if_done;
   logic                r_ls_done;
   logic                r_bus_error;
   logic                r_busy;

   assign w_in_access = (r_state == ST_ACCESS);

`ifdef RAM_TIMEOUT_EN
   ram_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_active (w_in_access),
      .i_mfc    (io_bus.MFC),
      .o_expired(w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Grant latch: owner, address and opcode frozen from grant until the next grant.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner      <= OWN_IF;
         r_last_owner <= OWN_IF;
         r_addr       <= 32'd0;
         r_opcode     <= {RAM_OP_W{1'b0}};
      end else if (w_grant) begin
         r_owner      <= w_grant_owner;
         r_last_owner <= w_grant_owner;
         r_addr       <= (w_grant_owner == OWN_LS) ? io_bus.ls_addr : io_bus.if_addr;
         r_opcode     <= (w_grant_owner == OWN_LS) ? io_bus.ls_opcode : FETCH_OPCODE;
      end
   end

   // Next-state and arbitration; ls wins contention unless it won the previous grant.
   always_comb begin
      w_next_state  = r_state;
      w_grant       = 1'b0;
      w_grant_owner = OWN_IF;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.ls_req && (!io_bus.if_req || (r_last_owner == OWN_IF))) begin
               w_grant       = 1'b1;
               w_grant_owner = OWN_LS;
               w_next_state  = ST_LOAD_MAR;
            end else if (io_bus.if_req) begin
               w_grant       = 1'b1;
               w_grant_owner = OWN_IF;
               w_next_state  = ST_LOAD_MAR;
            end else begin
               w_next_state  = ST_IDLE;
            end
         end
         ST_LOAD_MAR: w_next_state = ST_ACCESS;
         ST_ACCESS: begin
            if (io_bus.MFC || w_expired) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_ACCESS;
            end
         end
         ST_DONE:     w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   // Outputs decoded from the next state so the registered copies line up with the state.
   always_comb begin
      w_mar_enable = (w_next_state == ST_LOAD_MAR);
      w_ram_enable = (w_next_state == ST_ACCESS);
      if (w_next_state == ST_ACCESS) begin
         w_ram_opcode = r_opcode;
      end else begin
         w_ram_opcode = {RAM_OP_W{1'b0}};
      end
      w_if_done   = (w_next_state == ST_DONE) && (r_owner == OWN_IF);
      w_ls_done   = (w_next_state == ST_DONE) && (r_owner == OWN_LS);
      w_bus_error = w_in_access && w_expired;
      w_busy      = (w_next_state != ST_IDLE);
   end

   // Output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mar_enable <= 1'b0;
         r_ram_enable <= 1'b0;
         r_ram_opcode <= {RAM_OP_W{1'b0}};
         r_if_done    <= 1'b0;
         r_ls_done    <= 1'b0;
         r_bus_error  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_mar_enable <= w_mar_enable;
         r_ram_enable <= w_ram_enable;
         r_ram_opcode <= w_ram_opcode;
         r_if_done    <= w_if_done;
         r_ls_done    <= w_ls_done;
         r_bus_error  <= w_bus_error;
         r_busy       <= w_busy;
      end
   end

   assign io_bus.MAR_Enable = r_mar_enable;
   assign io_bus.mar_addr   = r_addr;
   assign io_bus.RAM_enable = r_ram_enable;
   assign io_bus.RAM_OpCode = r_ram_opcode;
   assign io_bus.if_done    = r_if_done;
   assign io_bus.ls_done    = r_ls_done;
   assign io_bus.bus_error  = r_bus_error;
   assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter; covers the watchdog too when RAM_TIMEOUT_EN is defined.
module tb_ram_access_arbiter;
   import sparc_mem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   ram_access_arbiter_if bus ();

`ifdef RAM_TIMEOUT_EN
   // Four wait cycles puts MFC exactly on the expiry cycle, where MFC must win.
   localparam int SLOW_WAIT = 3;
   ram_access_arbiter #(.TIMEOUT_CYCLES(4)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
`else
   localparam int SLOW_WAIT = 5;
   ram_access_arbiter dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"},    32'(bus.busy), 32'd0);
      chk({tag, ".strobes"}, 32'({bus.MAR_Enable, bus.RAM_enable}), 32'd0);
      chk({tag, ".done"},    32'({bus.if_done, bus.ls_done}), 32'd0);
      chk({tag, ".berr"},    32'(bus.bus_error), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk_idle(tag);
      chk({tag, ".mar_addr"}, bus.mar_addr, 32'd0);
      chk({tag, ".opcode"},   32'(bus.RAM_OpCode), 32'd0);
   endtask

   // Entered in the IDLE cycle with the request(s) already driven; returns in the DONE cycle.
   task automatic run_access(input string tag, input logic exp_ls, input logic [31:0] exp_addr,
                             input logic [5:0] exp_op, input int wait_cycles,
                             input logic scramble, input logic drop);
      @(negedge clk);
      chk({tag, ".mar_en"},   32'(bus.MAR_Enable), 32'd1);
      chk({tag, ".mar_addr"}, bus.mar_addr, exp_addr);
      chk({tag, ".ram_en_ld"}, 32'(bus.RAM_enable), 32'd0);
      for (int i = 0; i <= wait_cycles; i++) begin
         @(negedge clk);
         chk({tag, ".ram_en"},   32'(bus.RAM_enable), 32'd1);
         chk({tag, ".opcode"},   32'(bus.RAM_OpCode), 32'(exp_op));
         chk({tag, ".addr_acc"}, bus.mar_addr, exp_addr);
         chk({tag, ".done_acc"}, 32'({bus.if_done, bus.ls_done, bus.MAR_Enable}), 32'd0);
         if (scramble && (i == 0)) begin
            bus.ls_addr   = 32'hDEAD_BEEF;
            bus.ls_opcode = 6'b111111;
         end
         bus.MFC = (i == wait_cycles);
      end
      @(negedge clk);
      bus.MFC = 1'b0;
      chk({tag, ".done"},      32'({bus.if_done, bus.ls_done}), 32'({~exp_ls, exp_ls}));
      chk({tag, ".ram_en_dn"}, 32'(bus.RAM_enable), 32'd0);
      chk({tag, ".berr"},      32'(bus.bus_error), 32'd0);
      chk({tag, ".busy_dn"},   32'(bus.busy), 32'd1);
      if (drop) begin
         bus.if_req = 1'b0;
         bus.ls_req = 1'b0;
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'd0;
      bus.ls_req    = 1'b0;
      bus.ls_addr   = 32'd0;
      bus.ls_opcode = 6'b000000;
      bus.MFC       = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_idle("post_reset");

      // Lone fetch, MFC in the first ACCESS cycle.
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0040;
      run_access("fetch", 1'b0, 32'h0000_0040, FETCH_OPCODE, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk_idle("fetch_end");

      // Contention over three accesses: ls, if, ls.
      bus.if_addr   = 32'h0000_0200;
      bus.ls_addr   = 32'h0000_0100;
      bus.ls_opcode = 6'b000100;
      bus.if_req    = 1'b1;
      bus.ls_req    = 1'b1;
      run_access("cont1_ls", 1'b1, 32'h0000_0100, 6'b000100, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk_idle("cont1_gap");
      run_access("cont2_if", 1'b0, 32'h0000_0200, FETCH_OPCODE, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk_idle("cont2_gap");
      run_access("cont3_ls", 1'b1, 32'h0000_0100, 6'b000100, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk_idle("cont3_gap");

      // Slow memory with inputs changed after grant.
      bus.ls_addr   = 32'h0000_0700;
      bus.ls_opcode = 6'b000101;
      bus.ls_req    = 1'b1;
      run_access("slow", 1'b1, 32'h0000_0700, 6'b000101, SLOW_WAIT, 1'b1, 1'b1);
      @(negedge clk);
      chk_idle("slow_end");

      // Spurious MFC in IDLE and LOAD_MAR.
      bus.MFC = 1'b1;
      @(negedge clk);
      chk_idle("spur_idle");
      bus.ls_addr   = 32'h0000_0800;
      bus.ls_opcode = 6'b000010;
      bus.ls_req    = 1'b1;
      @(negedge clk);
      chk("spur_load.mar_en", 32'(bus.MAR_Enable), 32'd1);
      chk("spur_load.done",   32'({bus.if_done, bus.ls_done, bus.RAM_enable}), 32'd0);
      @(negedge clk);
      chk("spur_acc1.ram_en", 32'(bus.RAM_enable), 32'd1);
      bus.MFC = 1'b0;
      @(negedge clk);
      chk("spur_acc2.ram_en", 32'(bus.RAM_enable), 32'd1);
      chk("spur_acc2.done",   32'(bus.ls_done), 32'd0);
      bus.MFC = 1'b1;
      @(negedge clk);
      chk("spur_done.ls_done", 32'(bus.ls_done), 32'd1);
      bus.MFC    = 1'b0;
      bus.ls_req = 1'b0;
      @(negedge clk);
      chk_idle("spur_end");

      // Reset in the second ACCESS cycle of an ls access.
      bus.ls_addr   = 32'h0000_0300;
      bus.ls_opcode = 6'b001000;
      bus.ls_req    = 1'b1;
      @(negedge clk);
      chk("rst_load.mar_en", 32'(bus.MAR_Enable), 32'd1);
      @(negedge clk);
      chk("rst_acc1.ram_en", 32'(bus.RAM_enable), 32'd1);
      @(negedge clk);
      chk("rst_acc2.ram_en", 32'(bus.RAM_enable), 32'd1);
      rst        = 1'b1;
      bus.ls_req = 1'b0;
      @(negedge clk);
      chk_reset("rst_mid");
      rst = 1'b0;
      @(negedge clk);
      chk_idle("rst_after");
      bus.if_addr   = 32'h0000_0400;
      bus.ls_addr   = 32'h0000_0500;
      bus.ls_opcode = 6'b000100;
      bus.if_req    = 1'b1;
      bus.ls_req    = 1'b1;
      run_access("rst_cont", 1'b1, 32'h0000_0500, 6'b000100, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk_idle("rst_cont_end");

`ifdef RAM_TIMEOUT_EN
      // MFC never arrives: four ACCESS cycles, then done with bus_error.
      bus.if_addr = 32'h0000_0600;
      bus.if_req  = 1'b1;
      @(negedge clk);
      chk("to_load.mar_en", 32'(bus.MAR_Enable), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to_acc.ram_en", 32'(bus.RAM_enable), 32'd1);
         chk("to_acc.quiet",  32'({bus.if_done, bus.bus_error}), 32'd0);
      end
      @(negedge clk);
      chk("to_done.if_done", 32'(bus.if_done), 32'd1);
      chk("to_done.berr",    32'(bus.bus_error), 32'd1);
      chk("to_done.ram_en",  32'(bus.RAM_enable), 32'd0);
      bus.if_req = 1'b0;
      @(negedge clk);
      chk_idle("to_end");
      bus.if_addr = 32'h0000_0640;
      bus.if_req  = 1'b1;
      run_access("after_to", 1'b0, 32'h0000_0640, FETCH_OPCODE, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk_idle("after_to_end");
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
